// File: rtl/bus_region_sel_pkg.sv
// Shared definitions for the bus region decoder: FSM state encoding and a
// constant clog2 used to check the select-index width at elaboration.
package bus_region_sel_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StActive = 1'b1
  } state_e;

  // Smallest width able to index n selects, never less than 1 bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/bus_region_sel_if.sv
// Request/response bundle between the CPU bus master and the region decoder.
interface bus_region_sel_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NSEL   = 4,
  parameter int unsigned IDX_W  = 2
);

  logic              en;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [NSEL-1:0]   sel;
  logic [IDX_W-1:0]  sel_idx;
  logic              wr_q;
  logic              busy;
  logic              ready;
  logic              err;

  modport master (
    output en, wr, addr,
    input  sel, sel_idx, wr_q, busy, ready, err
  );

  modport slave (
    input  en, wr, addr,
    output sel, sel_idx, wr_q, busy, ready, err
  );

endinterface

// File: rtl/bus_region_sel_region_match.sv
// Single address-region comparator: hit when the masked address equals the
// masked base.
module bus_region_sel_region_match #(
  parameter int unsigned          ADDR_W = 16,
  parameter logic [ADDR_W-1:0]    BASE   = '0,
  parameter logic [ADDR_W-1:0]    MASK   = '0
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit
);

  assign hit = ((addr & MASK) == (BASE & MASK));

endmodule

// File: rtl/bus_region_sel.sv
// Registered memory-map decoder: priority region match, one-hot select held for
// the access, per-region wait states and a single-cycle ready/err completion.
module bus_region_sel
  import bus_region_sel_pkg::*;
#(
  parameter int unsigned              ADDR_W = 16,
  parameter int unsigned              NSEL   = 4,
  parameter int unsigned              IDX_W  = 2,
  parameter int unsigned              WAIT_W = 4,
  parameter logic [NSEL*ADDR_W-1:0]   BASES  = {16'hF000, 16'hFF00, 16'h8000, 16'h0000},
  parameter logic [NSEL*ADDR_W-1:0]   MASKS  = {16'hF000, 16'hFF00, 16'hC000, 16'h8000},
  parameter logic [NSEL*WAIT_W-1:0]   WAITS  = 16'h0012
) (
  input logic             clk,
  input logic             reset,
  bus_region_sel_if.slave bus
);

  if (IDX_W != clog2_min1(NSEL)) begin : g_bad_idx_w
    $error("bus_region_sel: IDX_W must equal clog2(NSEL)");
  end

  logic [NSEL-1:0]   hit;
  logic              hit_any;
  logic [IDX_W-1:0]  hit_idx;
  logic [NSEL-1:0]   hit_onehot;
  logic [WAIT_W-1:0] hit_wait;

  for (genvar i = 0; i < NSEL; i++) begin : g_region
    bus_region_sel_region_match #(
      .ADDR_W (ADDR_W),
      .BASE   (BASES[i*ADDR_W +: ADDR_W]),
      .MASK   (MASKS[i*ADDR_W +: ADDR_W])
    ) u_match (
      .addr (bus.addr),
      .hit  (hit[i])
    );
  end

  // Scan from the top down so the lowest hitting index is the last written.
  always_comb begin
    hit_any    = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    hit_wait   = '0;
    for (int i = int'(NSEL) - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any       = 1'b1;
        hit_idx       = IDX_W'(i);
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
        hit_wait      = WAITS[i*WAIT_W +: WAIT_W];
      end
    end
  end

  state_e            state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [NSEL-1:0]   sel_q;
  logic [IDX_W-1:0]  idx_q;
  logic              wr_hold_q;
  logic              miss_q;
  logic              ready_q;
  logic              err_q;

  // ready/err are set one edge early so they are registered yet appear in the
  // cycle where the counter reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sel_q     <= '0;
      idx_q     <= '0;
      wr_hold_q <= 1'b0;
      miss_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.en) begin
            state_q   <= StActive;
            wr_hold_q <= bus.wr;
            sel_q     <= hit_onehot;
            idx_q     <= hit_idx;
            cnt_q     <= hit_wait;
            miss_q    <= ~hit_any;
            ready_q   <= (hit_wait == '0);
            err_q     <= ~hit_any;
          end
        end
        StActive: begin
          if (cnt_q != '0) begin
            cnt_q   <= cnt_q - WAIT_W'(1);
            ready_q <= (cnt_q == WAIT_W'(1));
            err_q   <= miss_q && (cnt_q == WAIT_W'(1));
          end else begin
            state_q   <= StIdle;
            sel_q     <= '0;
            idx_q     <= '0;
            wr_hold_q <= 1'b0;
            miss_q    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.sel     = sel_q;
  assign bus.sel_idx = idx_q;
  assign bus.wr_q    = wr_hold_q;
  assign bus.busy    = (state_q == StActive);
  assign bus.ready   = ready_q;
  assign bus.err     = err_q;

endmodule

// File: doc/bus_region_sel.md
# bus_region_sel

Parametrised, registered memory-map decoder for the computer's system bus. Each access request is matched against NSEL address regions, each with its own base, mask and wait-state count. The block holds a one-hot peripheral select for the duration of the access and returns a single-cycle `ready` completion, or `err` on a map miss. It sits between the CPU bus master and the memory/peripheral slaves and replaces plain combinational chip-select generation.

## Interface
Parameters:
- `ADDR_W`, 16: address width.
- `NSEL`, 4: number of regions/selects, 1..16.
- `IDX_W`, 2: width of `sel_idx`; must equal clog2(NSEL), minimum 1.
- `WAIT_W`, 4: width of each wait-state count.
- `BASES`, {16'hF000,16'hFF00,16'h8000,16'h0000}: region i base at bits [i*ADDR_W +: ADDR_W].
- `MASKS`, {16'hF000,16'hFF00,16'hC000,16'h8000}: region i compare mask, same packing.
- `WAITS`, 16'h0012: region i wait states at [i*WAIT_W +: WAIT_W]. Default values: r0=2, r1=1, r2=0, r3=0.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: access request strobe; sampled only in IDLE.
- `wr` in 1: request is a write.
- `addr` in ADDR_W: request address.
- `sel` out NSEL: registered one-hot slave select.
- `sel_idx` out IDX_W: binary index of the selected region.
- `wr_q` out 1: `wr` captured at acceptance.
- `busy` out 1: high while in ACTIVE.
- `ready` out 1: single-cycle access completion.
- `err` out 1: single-cycle completion due to a map miss; always coincides with `ready`.

## Operation
- Hit rule: region i hits when (addr & MASK_i) == (BASE_i & MASK_i). If several regions hit, the lowest index wins.
- States: IDLE, ACTIVE.
- Accept: `en`=1 in IDLE captures the access on that edge, moves to ACTIVE, and latches `wr_q`.
  - On a hit to region k: `sel`=1<<k, `sel_idx`=k, `cnt`=WAITS_k.
  - On a miss: `sel`=0, `sel_idx`=0, `cnt`=0, miss flag set.
- ACTIVE with `cnt`≠0: decrement `cnt`.
- ACTIVE with `cnt`=0: assert `ready` that cycle, plus `err` if the miss flag is set. Next state is IDLE; `sel`, `sel_idx`, `wr_q` and the miss flag clear on that edge.
- `en` during ACTIVE is ignored, including the `ready` cycle; no queueing.
- `addr` and `wr` are not required to be stable after acceptance.
- Reset: state IDLE, `cnt`=0. All outputs 0: `sel`, `sel_idx`, `wr_q`, `busy`, `ready`, `err`.
- Reset during ACTIVE aborts the access. No `ready` is issued, and outputs are 0 from the next cycle.

## Timing
- Request accepted at edge T (`en`=1 in IDLE before T). `sel`/`busy` are valid from T, meaning the cycle after `en`.
- `ready` is high in cycle T+W, where W=WAITS_k; for a miss, W=0. Total latency is W+1 cycles from `en` to `ready`.
- `sel` stays stable from acceptance through the `ready` cycle inclusive.
- Maximum throughput: one access per W+2 cycles, since IDLE lasts at least 1 cycle between accesses.
- `ready`, `err`, `sel`, `busy` are all registered outputs with no combinational path from inputs.
- Simultaneous `reset` and `en`: reset wins and the request is dropped.

## Structure
- Shared include `bus_defs`: state encoding (IDLE=0, ACTIVE=1) and a constant clog2 function used to check IDX_W.
- Sub-module `region_match` (instantiated NSEL times via generate): inputs `addr`, parameters BASE and MASK; output `hit`.
- The top level contains the priority selection (lowest index), the index and one-hot encode, the wait counter and the FSM.

## Test plan
- Read at `addr`=16'h0123 → `sel`=4'b0001 and `sel_idx`=0 at T; `ready`=1 at T+2 only; `err`=0; `sel`=0 at T+3.
- Write at 16'h9000 → `sel`=4'b0010, `wr_q`=1, `ready` at T+1. A request at 16'hF010 issued during T is ignored: no `sel` change, and exactly one `ready` is seen.
- Overlap at 16'hFF10 → region 2 wins: `sel`=4'b0100, `ready` at T. At 16'hF010 → `sel`=4'b1000, `ready` at T.
- Miss at 16'hC000 → `sel`=0, `busy`=1 at T, and `ready`=`err`=1 at T, each for one cycle only.
- Reset asserted at T+1 of a region-0 access → all outputs 0 at T+2 and no `ready` ever; a new request at 16'h0000 then completes normally after 3 cycles.
- Back-to-back region-2 requests with `en` held high → `ready` every 2nd cycle; `busy` toggles 1,0,1,0.
